// File: rtl/instruction_prefetch_queue.sv
// ============================================================================
// instruction_prefetch_queue
//
// Sequential instruction prefetcher sitting between the branch unit / icache
// and decode. It issues fetch requests at consecutive PCs, keeps up to
// MAX_OUTSTANDING cache requests in flight, and buffers returned instructions
// together with their PCs in a DEPTH-entry FIFO. A redirect flushes the FIFO,
// restarts fetch at redirect_pc and marks every in-flight response as stale.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   redirect_valid/pc flush and restart fetch at redirect_pc
//   req_valid/ready   cache request handshake, req_addr = current fetch PC
//   rsp_valid/data    in-order cache responses, no backpressure
//   out_valid/ready   decode handshake, out_instr/out_pc = FIFO head
//   occupancy         number of valid FIFO entries
// ============================================================================
module instruction_prefetch_queue #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INSTR_WIDTH     = 32,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter int                    WORD_BYTES      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      rsp_valid,
    input  logic [INSTR_WIDTH-1:0]    rsp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_WIDTH-1:0]    out_instr,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(MAX_OUTSTANDING - 1);

    logic [ADDR_WIDTH-1:0]  r_fetch_pc;
    logic [OW-1:0]          r_inflight;
    logic [OW-1:0]          r_drop_cnt;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_pc_mem    [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_pcq_mem   [MAX_OUTSTANDING];
    logic [QW-1:0]          r_pcq_wr;
    logic [QW-1:0]          r_pcq_rd;

    logic          w_credit_ok;
    logic          w_space_ok;
    logic          w_req_fire;
    logic          w_rsp_live;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_inflight_nxt;
    logic [OW-1:0] w_drop_nxt;
    logic [QW-1:0] w_pcq_wr_inc;
    logic [QW-1:0] w_pcq_rd_inc;

    always_comb begin
        // Stale responses still occupy cache slots, so they count against the
        // outstanding limit. Reserving a FIFO slot for every live request means
        // a response can always be written without an overflow check.
        w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_drop_cnt}) < (OW+1)'(MAX_OUTSTANDING);
        w_space_ok  = ({1'b0, r_count} + (CW+1)'(r_inflight)) < (CW+1)'(DEPTH);

        req_valid  = !redirect_valid && w_credit_ok && w_space_ok;
        req_addr   = r_fetch_pc;
        w_req_fire = req_valid && req_ready;

        w_rsp_live = rsp_valid && (r_drop_cnt == '0);
        w_push     = w_rsp_live && !redirect_valid;

        out_valid  = (r_count != '0) && !redirect_valid;
        out_instr  = r_instr_mem[r_rd_ptr];
        out_pc     = r_pc_mem[r_rd_ptr];
        occupancy  = r_count;
        w_pop      = out_valid && out_ready;

        w_pcq_wr_inc = (r_pcq_wr == Q_LAST) ? '0 : r_pcq_wr + QW'(1);
        w_pcq_rd_inc = (r_pcq_rd == Q_LAST) ? '0 : r_pcq_rd + QW'(1);

        w_inflight_nxt = r_inflight;
        if (w_req_fire && !w_rsp_live) begin
            w_inflight_nxt = r_inflight + OW'(1);
        end else if (!w_req_fire && w_rsp_live) begin
            w_inflight_nxt = r_inflight - OW'(1);
        end

        // On redirect every live request turns stale; a response arriving in
        // the redirect cycle itself is discarded right away and not counted.
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_nxt = r_drop_cnt + r_inflight - OW'(rsp_valid);
        end else if (rsp_valid && !w_rsp_live) begin
            w_drop_nxt = r_drop_cnt - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= '0;
            r_drop_cnt <= w_drop_nxt;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // The PC queue is left alone apart from the normal pop: the stale
            // responses consume exactly the entries of the flushed requests,
            // so the first live response lines up with the entry written by
            // the first request to redirect_pc.
            if (rsp_valid) begin
                r_pcq_rd <= w_pcq_rd_inc;
            end
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(WORD_BYTES);
                r_pcq_wr   <= w_pcq_wr_inc;
            end
            if (rsp_valid) begin
                r_pcq_rd <= w_pcq_rd_inc;
            end
            r_inflight <= w_inflight_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= rsp_data;
            r_pc_mem[r_wr_ptr]    <= r_pcq_mem[r_pcq_rd];
        end
        if (w_req_fire) begin
            r_pcq_mem[r_pcq_wr] <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
module tb_instruction_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  occupancy;

    always #5 clk = ~clk;

    instruction_prefetch_queue #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4),
        .MAX_OUTSTANDING(2), .WORD_BYTES(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .occupancy(occupancy)
    );

    typedef struct { int due; logic [31:0] data; int epoch; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct {
        logic redir; logic [31:0] rpc; logic rdy; logic rsp; logic ordy;
        logic erv; logic [31:0] eaddr; logic eov; logic [2:0] eocc;
    } vec_t;

    pend_t pend[$];
    exp_t  expq[$];
    vec_t  tbl[22];

    int tests = 0, fails = 0;
    int cyc = 0, lat = 1, epoch = 0, rsp_epoch = 0, model_occ = 0;
    bit cache_en = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_addr, exp_pc;
    logic        s_rv, s_ov, s_fire, s_pop;
    logic [31:0] s_addr, s_pc;
    logic [2:0]  s_occ;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic vec_t mk(int rd, int rpc, int rdy, int rsp, int ordy,
                                int erv, int ea, int eov, int eocc);
        vec_t v;
        v.redir = 1'(rd);  v.rpc = 32'(rpc); v.rdy = 1'(rdy); v.rsp = 1'(rsp);
        v.ordy = 1'(ordy); v.erv = 1'(erv); v.eaddr = 32'(ea); v.eov = 1'(eov);
        v.eocc = 3'(eocc);
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache model: returns the oldest pending response when asked to.
    task automatic drive_rsp(bit go);
        if (go && pend.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = pend[0].data;
            rsp_epoch = pend[0].epoch;
            void'(pend.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    // One clock cycle: sample and check at negedge, update the reference
    // model for the coming edge, then drive the next cache response.
    task automatic tick();
        exp_t e;
        bit   live;
        @(negedge clk);
        s_rv = req_valid; s_addr = req_addr; s_ov = out_valid;
        s_pc = out_pc; s_occ = occupancy;
        s_fire = req_valid && req_ready;
        s_pop  = out_valid && out_ready;
        chk("occupancy", 32'(occupancy), model_occ);
        if (prev_hold && !redirect_valid) begin
            chk("req_hold_valid", 32'(req_valid), 32'd1);
            chk("req_hold_addr", req_addr, prev_addr);
        end
        if (redirect_valid) begin
            chk("redirect_req_valid", 32'(req_valid), 32'd0);
            chk("redirect_out_valid", 32'(out_valid), 32'd0);
        end
        if (s_fire) chk("req_addr", req_addr, exp_pc);
        if (s_pop) begin
            if (expq.size() == 0) begin
                tests++; fails++;
                $display("FAIL out_unexpected: got pc 0x%0h, want no output", out_pc);
            end else begin
                e = expq.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
            end
        end
        prev_hold = s_rv && !req_ready && !redirect_valid;
        prev_addr = req_addr;
        if (redirect_valid) begin
            epoch++;
            expq.delete();
            model_occ = 0;
            exp_pc = redirect_pc;
        end else begin
            live = rsp_valid && (rsp_epoch == epoch);
            if (s_fire) begin
                pend.push_back('{cyc + lat, instr_of(req_addr), epoch});
                expq.push_back('{req_addr, instr_of(req_addr)});
                exp_pc = exp_pc + 32'd4;
            end
            model_occ = model_occ + int'(live) - int'(s_pop);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cache_en) drive_rsp(pend.size() > 0 && pend[0].due <= cyc);
        else          drive_rsp(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        pend.delete(); expq.delete();
        model_occ = 0; exp_pc = 32'h0; prev_hold = 1'b0; epoch++;
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd1);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_pop(string name, logic [31:0] want);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (s_pop) begin
                got = 1'b1;
                chk(name, s_pc, want);
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s: got no output within 30 cycles, want pc 0x%0h", name, want);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nf;
        int          nw;
        bit          found;
        logic [31:0] wa [3];

        //            redir rpc    rdy rsp ordy | rv addr   ov occ
        tbl[0]  = mk(0, 0,      0, 0, 0,  1, 32'h000, 0, 0);
        tbl[1]  = mk(0, 0,      1, 0, 0,  1, 32'h000, 0, 0);
        tbl[2]  = mk(0, 0,      1, 0, 0,  1, 32'h004, 0, 0);
        tbl[3]  = mk(0, 0,      1, 0, 0,  0, 32'h008, 0, 0);
        tbl[4]  = mk(0, 0,      1, 1, 0,  0, 32'h008, 0, 0);
        tbl[5]  = mk(0, 0,      0, 0, 0,  1, 32'h008, 1, 1);
        tbl[6]  = mk(1, 32'h100,1, 1, 1,  0, 32'h008, 0, 1);
        tbl[7]  = mk(0, 0,      0, 0, 1,  1, 32'h100, 0, 0);
        tbl[8]  = mk(0, 0,      1, 0, 1,  1, 32'h100, 0, 0);
        tbl[9]  = mk(0, 0,      1, 1, 1,  1, 32'h104, 0, 0);
        tbl[10] = mk(0, 0,      0, 0, 1,  1, 32'h108, 1, 1);
        tbl[11] = mk(0, 0,      0, 1, 0,  1, 32'h108, 0, 0);
        tbl[12] = mk(0, 0,      0, 0, 0,  1, 32'h108, 1, 1);
        tbl[13] = mk(0, 0,      1, 0, 0,  1, 32'h108, 1, 1);
        tbl[14] = mk(0, 0,      1, 0, 0,  1, 32'h10C, 1, 1);
        tbl[15] = mk(1, 32'h200,1, 0, 0,  0, 32'h110, 0, 1);
        tbl[16] = mk(0, 0,      1, 0, 0,  0, 32'h200, 0, 0);
        tbl[17] = mk(0, 0,      1, 1, 0,  0, 32'h200, 0, 0);
        tbl[18] = mk(0, 0,      1, 1, 0,  1, 32'h200, 0, 0);
        tbl[19] = mk(0, 0,      0, 0, 0,  1, 32'h204, 0, 0);
        tbl[20] = mk(0, 0,      0, 1, 1,  1, 32'h204, 0, 0);
        tbl[21] = mk(0, 0,      0, 0, 1,  1, 32'h204, 1, 1);

        // Credit gating, drops and redirects with hand-timed responses.
        do_reset();
        cache_en = 1'b0;
        for (int i = 0; i < 22; i++) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            req_ready      = tbl[i].rdy;
            out_ready      = tbl[i].ordy;
            drive_rsp(tbl[i].rsp);
            tick();
            chk($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].erv));
            chk($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].eaddr);
            chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].eov));
            chk($sformatf("vec%0d_occupancy", i), 32'(s_occ), 32'(tbl[i].eocc));
        end
        redirect_valid = 1'b0;

        // Streaming, 1-cycle cache latency.
        do_reset();
        cache_en = 1'b1; lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stream_occ_le1", 32'(s_occ <= 3'd1), 32'd1);
            if (k >= 2) begin
                chk("stream_valid", 32'(s_ov), 32'd1);
                chk("stream_pc", s_pc, 32'((k - 2) * 4));
            end
        end

        // Fill under stall, then drain.
        do_reset();
        cache_en = 1'b1; lat = 1; req_ready = 1'b1; out_ready = 1'b0;
        nf = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (s_fire) nf++;
        end
        chk("fill_requests", 32'(nf), 32'd4);
        chk("fill_occupancy", 32'(s_occ), 32'd4);
        chk("fill_req_valid", 32'(s_rv), 32'd0);
        out_ready = 1'b1;
        nf = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (s_fire) nf++;
            chk("drain_pop", 32'(s_pop), 32'd1);
            chk("drain_pc", s_pc, 32'(k * 4));
        end
        chk("drain_resume", 32'(nf > 0), 32'd1);
        repeat (6) tick();

        // Redirect with two responses in flight, 2-cycle latency.
        do_reset();
        cache_en = 1'b1; lat = 2; req_ready = 1'b1; out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (s_fire && s_addr == 32'hC) found = 1'b1;
        end
        chk("rd_setup_fire_c", 32'(found), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        chk("rd_out_valid", 32'(s_ov), 32'd0);
        redirect_valid = 1'b0;
        wait_pop("rd_first_pc", 32'h100);
        repeat (4) tick();

        // Redirect coincident with a response and a pop.
        do_reset();
        cache_en = 1'b1; lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("co_out_valid", 32'(s_ov), 32'd0);
        chk("co_pop", 32'(s_pop), 32'd0);
        redirect_valid = 1'b0;
        tick();
        chk("co_occupancy", 32'(s_occ), 32'd0);
        wait_pop("co_first_pc", 32'h40);
        repeat (4) tick();

        // Address wrap with random request and output backpressure.
        do_reset();
        cache_en = 1'b1; lat = 2; req_ready = 1'b0; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        nw = 0;
        wa = '{default: '0};
        for (int k = 0; k < 80; k++) begin
            req_ready = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (s_fire && nw < 3) begin
                wa[nw] = s_addr;
                nw++;
            end
        end
        chk("wrap_count", 32'(nw), 32'd3);
        chk("wrap_a0", wa[0], 32'hFFFF_FFF8);
        chk("wrap_a1", wa[1], 32'hFFFF_FFFC);
        chk("wrap_a2", wa[2], 32'h0000_0000);

        // Asynchronous reset mid-burst.
        do_reset();
        cache_en = 1'b1; lat = 1; req_ready = 1'b1; out_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (occupancy == 3'd3) found = 1'b1;
        end
        chk("ar_setup_occ3", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        rsp_valid = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_occupancy", 32'(occupancy), 32'd0);
        do_reset();
        chk("ar_req_addr_after", req_addr, 32'h0);
        cache_en = 1'b1; lat = 1; req_ready = 1'b1; out_ready = 1'b1;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Parametrised successor to the core's single-issue fetch stage: generates sequential fetch addresses, keeps up to `MAX_OUTSTANDING` instruction-cache requests in flight, and buffers returned instructions with their PCs in a `DEPTH`-entry FIFO. It supports decode-side backpressure and redirects (branch or exception) that discard in-flight responses. It sits between the branch unit/icache and the decode stage of the core pipeline.

## Interface
- `ADDR_WIDTH`, 32: PC / request address width.
- `INSTR_WIDTH`, 32: instruction width.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `MAX_OUTSTANDING`, 2: max in-flight cache requests, 1..DEPTH.
- `WORD_BYTES`, 4: PC increment per instruction.
- `RESET_PC`, 0: fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address.
- `req_valid`  out  1  cache request valid.
- `req_ready`  in  1  cache accepts request.
- `req_addr`  out  ADDR_WIDTH  request address.
- `rsp_valid`  in  1  cache response, in request order, ≥1 cycle after accept, no backpressure.
- `rsp_data`  in  INSTR_WIDTH  returned instruction.
- `out_valid`  out  1  instruction available to decode.
- `out_ready`  in  1  decode accepts (low = pipeline stall).
- `out_instr`  out  INSTR_WIDTH  head instruction.
- `out_pc`  out  ADDR_WIDTH  PC of head instruction.
- `occupancy`  out  $clog2(DEPTH)+1  valid FIFO entries (debug/perf).

## Operation
- State: `fetch_pc`, `inflight` (live requests), `drop_cnt` (stale responses to discard), FIFO storage {instr, pc}, and `rd_ptr`/`wr_ptr`/`count`. Pointers are $clog2(DEPTH) bits and wrap naturally. `count` is $clog2(DEPTH)+1 bits.
- Request gating: `req_valid = !redirect_valid && (inflight + drop_cnt) < MAX_OUTSTANDING && (count + inflight) < DEPTH`. This credit rule guarantees every live response has a free slot, so there is no overflow path.
- `req_addr = fetch_pc`. On a handshake, `fetch_pc += WORD_BYTES` (modulo 2^ADDR_WIDTH wrap) and `inflight` is incremented.
- A per-request PC queue (MAX_OUTSTANDING deep) records `req_addr` on accept. It is popped on every `rsp_valid`.
- Response with `drop_cnt == 0`: push {rsp_data, popped pc} into the FIFO and decrement `inflight`.
- Response with `drop_cnt > 0`: discard it and decrement `drop_cnt`.
- Output: `out_valid = count != 0 && !redirect_valid`. `out_instr`/`out_pc` are the head entry. The head pops when `out_valid && out_ready`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. A push and pop can both occur when `count == DEPTH-1`, or when full only with a pop.
- Redirect has highest priority over everything else. At the edge where `redirect_valid == 1`:
  - FIFO is cleared (`count`, `rd_ptr`, `wr_ptr` ← 0).
  - `fetch_pc` ← `redirect_pc`.
  - `drop_cnt` ← `drop_cnt + inflight − (rsp_valid ? 1 : 0)`.
  - `inflight` ← 0.
  - The PC queue is re-aligned so that the first response after the drops pairs with `redirect_pc`.
- Back-to-back redirects: each redirect accumulates into `drop_cnt` and the last `redirect_pc` wins.
- Reset (async, any time including mid-operation): `fetch_pc=RESET_PC`, with all counters, pointers, `inflight` and `drop_cnt` set to 0. Responses that arrive after reset are the integrator's responsibility (the cache is reset together with this block).

## Timing
- Reset values: `req_valid=1` (the gate is open once `rst` deasserts), `req_addr=RESET_PC`, `out_valid=0`, `occupancy=0`. `out_instr`/`out_pc` are don't-care while `out_valid=0`.
- `req_valid` and `out_valid` are combinational from registered state plus `redirect_valid`. Neither depends on `req_ready` or `out_ready`.
- Latency from response to output: `rsp_valid` in cycle N gives `out_valid` in cycle N+1 if the FIFO was empty. There is no combinational rsp→out path.
- `req_valid` must not depend on `req_ready`. Once asserted, it may drop only on redirect.
- Redirect cycle: `req_valid=0` and `out_valid=0`. The first request to `redirect_pc` is issued in the following cycle.
- Steady state with single-cycle cache latency, `MAX_OUTSTANDING ≥ 2` and `out_ready=1`: one instruction per cycle.

## Test plan
- **Reset and streaming:** release `rst`, with `req_ready=1`, 1-cycle response latency, `out_ready=1`. Required: `req_addr` sequence 0x0,0x4,0x8…; `out_pc` sequence 0x0,0x4…; one instruction per cycle from cycle 3 onward; `occupancy ≤ 1`.
- **Fill under stall:** hold `out_ready=0`. Required: exactly DEPTH=4 requests issued, `occupancy` reaches 4, then `req_valid=0`. Releasing `out_ready` drains 0x0..0xC in order, and requests resume.
- **Redirect with responses in flight:** set 2-cycle latency and 2 outstanding requests (0x8, 0xC), then pulse `redirect_valid` with `redirect_pc=0x100`. Required: both stale responses are dropped, the next `out_pc=0x100`, and `out_valid=0` during the redirect cycle.
- **Redirect coincident with response and pop:** in one cycle apply `rsp_valid`, `out_ready=1` and `redirect_valid` (`redirect_pc=0x40`). Required: no instruction is delivered, `occupancy=0` next cycle, `drop_cnt` accounts for the coincident response, and the first output is 0x40.
- **Wrap and backpressure:** `redirect_pc=0xFFFF_FFF8`, `req_ready` toggling randomly. Required: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; `req_addr` is held stable while unaccepted; outputs are in order.
- **Async reset mid-burst:** assert `rst` with `occupancy=3` and 1 request in flight. Required: `out_valid=0` and `occupancy=0` immediately, and `req_addr=RESET_PC` after release.
